// File: rtl/ibuf_pkg.sv
// Shared types and helpers for the N-wide instruction queue.
package ibuf_pkg;

    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_branch;
        logic        pred_taken;
    } entry_t;

    // Length of the run of set bits starting at bit 0, limited to width bits.
    function automatic int run_len(input logic [3:0] mask, input int width);
        int   n;
        logic stop;
        n    = 0;
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < width && !stop && mask[i]) n++;
            else stop = 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/ibuf_storage.sv
// DEPTH-entry register file: FETCH_W write ports at base+offset, ISSUE_W async read ports.
module ibuf_storage
    import ibuf_pkg::*;
#(
    parameter  int DEPTH   = 8,
    parameter  int FETCH_W = 2,
    parameter  int ISSUE_W = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic [FETCH_W-1:0]         i_we,
    input  logic [AW-1:0]              i_wr_base,
    input  entry_t [FETCH_W-1:0]       i_wr_data,
    input  logic [AW-1:0]              i_rd_base,
    output entry_t [ISSUE_W-1:0]       o_rd_data
);

    entry_t r_mem [DEPTH];

    // Contents are deliberately not reset; the queue's count gates validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (i_we[i]) r_mem[i_wr_base + AW'(i)] <= i_wr_data[i];
        end
    end

    always_comb begin
        for (int j = 0; j < ISSUE_W; j++) begin
            o_rd_data[j] = r_mem[i_rd_base + AW'(j)];
        end
    end

endmodule

// File: rtl/inst_queue_nw.sv
// Circular instruction queue between fetch and the N-wide decoder, with partial
// consumption, flush and optional issue-group split after a predicted-taken branch.
module inst_queue_nw
    import ibuf_pkg::*;
#(
    parameter  int FETCH_W  = 2,
    parameter  int ISSUE_W  = 2,
    parameter  int DEPTH    = 8,
    parameter  int BR_SPLIT = 1,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int ACCW     = $clog2(ISSUE_W + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    fetch_valid_i,
    input  logic [31:0]             fetch_pc_i,
    input  logic [32*FETCH_W-1:0]   fetch_inst_i,
    input  logic [FETCH_W-1:0]      fetch_mask_i,
    input  logic [FETCH_W-1:0]      fetch_br_i,
    input  logic [FETCH_W-1:0]      fetch_pred_i,
    output logic                    fetch_ready_o,
    output logic [ISSUE_W-1:0]      issue_valid_o,
    output logic [32*ISSUE_W-1:0]   issue_pc_o,
    output logic [32*ISSUE_W-1:0]   issue_inst_o,
    output logic [ISSUE_W-1:0]      issue_br_o,
    output logic [ISSUE_W-1:0]      issue_pred_o,
    input  logic [ACCW-1:0]         issue_accept_i,
    output logic [CW-1:0]           count_o
);

    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [3:0]            w_mask4;
    logic                  w_push;
    logic [CW-1:0]         w_push_n;
    logic [FETCH_W-1:0]    w_we;
    entry_t [FETCH_W-1:0]  w_wdata;
    entry_t [ISSUE_W-1:0]  w_rdata;
    logic                  w_cut;
    logic [ACCW-1:0]       w_vcnt;
    logic [ACCW-1:0]       w_pop_n;

    // Ready looks only at the registered count, never at this cycle's pop.
    assign fetch_ready_o = (CW'(DEPTH) - r_count) >= CW'(FETCH_W);
    assign count_o       = r_count;
    assign w_push        = fetch_valid_i && fetch_ready_o && !flush_i;

    always_comb begin
        w_mask4                = '0;
        w_mask4[FETCH_W-1:0]   = fetch_mask_i;
    end

    assign w_push_n = w_push ? CW'(run_len(w_mask4, FETCH_W)) : '0;

    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            w_we[i]               = CW'(i) < w_push_n;
            w_wdata[i].pc         = fetch_pc_i + 32'(INST_BYTES * i);
            w_wdata[i].inst       = fetch_inst_i[32*i +: 32];
            w_wdata[i].is_branch  = fetch_br_i[i];
            w_wdata[i].pred_taken = fetch_pred_i[i];
        end
    end

    ibuf_storage #(
        .DEPTH   (DEPTH),
        .FETCH_W (FETCH_W),
        .ISSUE_W (ISSUE_W)
    ) u_storage (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_base (r_wr_ptr),
        .i_wr_data (w_wdata),
        .i_rd_base (r_rd_ptr),
        .o_rd_data (w_rdata)
    );

    // Lanes form a thermometer; a predicted-taken branch closes the group.
    always_comb begin
        w_cut         = 1'b0;
        w_vcnt        = '0;
        issue_valid_o = '0;
        issue_pc_o    = '0;
        issue_inst_o  = '0;
        issue_br_o    = '0;
        issue_pred_o  = '0;
        for (int j = 0; j < ISSUE_W; j++) begin
            if (CW'(j) < r_count && !w_cut) begin
                issue_valid_o[j]     = 1'b1;
                issue_pc_o[32*j +: 32]   = w_rdata[j].pc;
                issue_inst_o[32*j +: 32] = w_rdata[j].inst;
                issue_br_o[j]        = w_rdata[j].is_branch;
                issue_pred_o[j]      = w_rdata[j].pred_taken;
                w_vcnt               = w_vcnt + ACCW'(1);
                if (BR_SPLIT != 0 && w_rdata[j].is_branch && w_rdata[j].pred_taken)
                    w_cut = 1'b1;
            end
        end
    end

    assign w_pop_n = (issue_accept_i < w_vcnt) ? issue_accept_i : w_vcnt;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop_n);
            r_count  <= r_count + w_push_n - CW'(w_pop_n);
        end
    end

endmodule

// File: tb/tb_inst_queue_nw.sv
// Self-checking bench: directed plan steps then random traffic, compared to a queue model.
module tb_inst_queue_nw;

    localparam int FW = 2, IW = 2, DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        fv;
    logic [31:0] fpc;
    logic [63:0] finst;
    logic [1:0]  fmask, fbr, fpred;
    logic [1:0]  acc;

    logic        rdy0, rdy1;
    logic [1:0]  val0, val1, br0, br1, pr0, pr1;
    logic [63:0] pc0, pc1, in0, in1;
    logic [3:0]  cnt0, cnt1;

    always #5 clk = ~clk;

    inst_queue_nw #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(DEPTH), .BR_SPLIT(1)) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush), .fetch_valid_i(fv), .fetch_pc_i(fpc),
        .fetch_inst_i(finst), .fetch_mask_i(fmask), .fetch_br_i(fbr), .fetch_pred_i(fpred),
        .fetch_ready_o(rdy0), .issue_valid_o(val0), .issue_pc_o(pc0), .issue_inst_o(in0),
        .issue_br_o(br0), .issue_pred_o(pr0), .issue_accept_i(acc), .count_o(cnt0));

    inst_queue_nw #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(DEPTH), .BR_SPLIT(0)) dut1 (
        .clk(clk), .rst(rst), .flush_i(flush), .fetch_valid_i(fv), .fetch_pc_i(fpc),
        .fetch_inst_i(finst), .fetch_mask_i(fmask), .fetch_br_i(fbr), .fetch_pred_i(fpred),
        .fetch_ready_o(rdy1), .issue_valid_o(val1), .issue_pc_o(pc1), .issue_inst_o(in1),
        .issue_br_o(br1), .issue_pred_o(pr1), .issue_accept_i(acc), .count_o(cnt1));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        br;
        logic        pred;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Number of lanes the decoder may see for a given queue content.
    function automatic int vis_n(input ent_t q[$], input bit split);
        int n;
        n = (q.size() < IW) ? q.size() : IW;
        if (split)
            for (int k = 0; k < n; k++)
                if (q[k].br && q[k].pred) return k + 1;
        return n;
    endfunction

    task automatic upd(inout ent_t q[$], input bit split);
        int   pop;
        bit   ready;
        ent_t e;
        ready = (DEPTH - q.size()) >= FW;
        if (rst || flush) begin
            q.delete();
            return;
        end
        pop = vis_n(q, split);
        if (int'(acc) < pop) pop = int'(acc);
        for (int i = 0; i < pop; i++) void'(q.pop_front());
        if (fv && ready) begin
            for (int i = 0; i < FW; i++) begin
                if (!fmask[i]) break;
                e.pc   = fpc + 32'(4 * i);
                e.inst = finst[32*i +: 32];
                e.br   = fbr[i];
                e.pred = fpred[i];
                q.push_back(e);
            end
        end
    endtask

    task automatic check_dut0();
        int n;
        logic [1:0] ev;
        n  = vis_n(q0, 1'b1);
        ev = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
        chk("d0_ready", 32'(rdy0), 32'((DEPTH - q0.size()) >= FW));
        chk("d0_count", 32'(cnt0), 32'(q0.size()));
        chk("d0_valid", 32'(val0), 32'(ev));
        for (int j = 0; j < IW; j++) begin
            chk("d0_pc",   pc0[32*j +: 32], (j < n) ? q0[j].pc : 32'h0);
            chk("d0_inst", in0[32*j +: 32], (j < n) ? q0[j].inst : 32'h0);
            chk("d0_bp",   32'({br0[j], pr0[j]}), (j < n) ? 32'({q0[j].br, q0[j].pred}) : 32'h0);
        end
    endtask

    task automatic check_dut1();
        int n;
        n = vis_n(q1, 1'b0);
        chk("d1_count", 32'(cnt1), 32'(q1.size()));
        chk("d1_valid", 32'(val1), (n == 0) ? 32'h0 : (n == 1) ? 32'h1 : 32'h3);
        chk("d1_pc0",   pc1[31:0], (n > 0) ? q1[0].pc : 32'h0);
    endtask

    // Check current outputs, clock once with the driven inputs, advance the model.
    task automatic cycle();
        check_dut0();
        check_dut1();
        @(posedge clk);
        upd(q0, 1'b1);
        upd(q1, 1'b0);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [1:0] m,
                         input logic [1:0] b, input logic [1:0] p, input logic [1:0] a,
                         input bit fl);
        fv    = v;
        fpc   = pc;
        finst = {$urandom, $urandom};
        fmask = m;
        fbr   = b;
        fpred = p;
        acc   = a;
        flush = fl;
        cycle();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; fv = 1'b0; fpc = '0; finst = '0;
        fmask = '0; fbr = '0; fpred = '0; acc = '0;
        @(posedge clk); #1;
        cycle();
        chk("rst_count", 32'(cnt0), 32'h0);
        chk("rst_ready", 32'(rdy0), 32'h1);
        rst = 1'b0;

        // single push
        fv = 1'b1; fpc = 32'h1c000000; finst = {32'h00101063, 32'h02800421};
        fmask = 2'b11; fbr = '0; fpred = '0; acc = '0; flush = 1'b0;
        cycle();
        fv = 1'b0;
        chk("t1_valid", 32'(val0), 32'h3);
        chk("t1_pc0", pc0[31:0], 32'h1c000000);
        chk("t1_pc1", pc0[63:32], 32'h1c000004);
        chk("t1_inst0", in0[31:0], 32'h02800421);
        chk("t1_count", 32'(cnt0), 32'h2);

        // fill to DEPTH, then an ignored push
        for (int i = 1; i < 4; i++) drive(1, 32'h1c000000 + 32'(8 * i), 2'b11, 2'b00, 2'b00, 2'd0, 0);
        chk("t2_count", 32'(cnt0), 32'h8);
        chk("t2_ready", 32'(rdy0), 32'h0);
        drive(1, 32'h1c000100, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        chk("t2_hold", 32'(cnt0), 32'h8);

        // drain to rd_ptr = 6, refill to 6, then push + pop across the wrap
        for (int i = 0; i < 3; i++) drive(0, 32'h0, 2'b00, 2'b00, 2'b00, 2'd2, 0);
        drive(1, 32'h1c000020, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        drive(1, 32'h1c000028, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        chk("t3_pre", 32'(cnt0), 32'h6);
        drive(1, 32'h1c000030, 2'b11, 2'b00, 2'b00, 2'd1, 0);
        chk("t3_count", 32'(cnt0), 32'h7);
        chk("t3_lane0", pc0[31:0], 32'h1c00001c);
        chk("t3_lane1", pc0[63:32], 32'h1c000020);

        // mask handling
        drive(0, 32'h0, 2'b00, 2'b00, 2'b00, 2'd0, 1);
        drive(1, 32'h00001000, 2'b10, 2'b00, 2'b00, 2'd0, 0);
        chk("t4_m10", 32'(cnt0), 32'h0);
        drive(1, 32'h00001000, 2'b01, 2'b00, 2'b00, 2'd0, 0);
        chk("t4_m01", 32'(val0), 32'h1);

        // branch split and accept clamp
        drive(0, 32'h0, 2'b00, 2'b00, 2'b00, 2'd0, 1);
        drive(1, 32'h00002000, 2'b11, 2'b01, 2'b01, 2'd0, 0);
        chk("t5_split", 32'(val0), 32'h1);
        chk("t5_nosplit", 32'(val1), 32'h3);
        drive(0, 32'h0, 2'b00, 2'b00, 2'b00, 2'd2, 0);
        chk("t5_clamp", 32'(cnt0), 32'h1);
        chk("t5_shift", pc0[31:0], 32'h00002004);
        chk("t5_d1_cnt", 32'(cnt1), 32'h0);

        // flush and reset priority over push/pop
        drive(0, 32'h0, 2'b00, 2'b00, 2'b00, 2'd0, 1);
        drive(1, 32'h00003000, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        drive(1, 32'h00003008, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        drive(1, 32'h00003010, 2'b01, 2'b00, 2'b00, 2'd0, 0);
        chk("t6_pre", 32'(cnt0), 32'h5);
        drive(1, 32'h00003020, 2'b11, 2'b00, 2'b00, 2'd2, 1);
        chk("t6_fl_cnt", 32'(cnt0), 32'h0);
        chk("t6_fl_val", 32'(val0), 32'h0);
        drive(1, 32'h00004000, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        drive(1, 32'h00004008, 2'b01, 2'b00, 2'b00, 2'd0, 0);
        rst = 1'b1;
        drive(1, 32'h00004010, 2'b11, 2'b00, 2'b00, 2'd2, 0);
        rst = 1'b0;
        chk("t6_rst_cnt", 32'(cnt0), 32'h0);
        chk("t6_rst_val", 32'(val0), 32'h0);

        // random traffic
        fpc = 32'h1c010000;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0, fpc, 2'($urandom), 2'($urandom), 2'($urandom),
                  2'($urandom_range(0, 2)), $urandom_range(0, 39) == 0);
            fpc = fpc + 32'h8;
        end
        rst = 1'b0;
        check_dut0();
        check_dut1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
